alu_nibble_seq: RTL and testbench

- Initiator side of the 4-bit ALU slice interface.
- Accepts a WIDTH-bit operation over a valid/ready request channel and drives an external 4-bit slice one nibble per cycle, LSB nibble first.
- Chains the slice carry through a register and assembles the wide result, returned on a valid/ready response channel.
- Sits between the instruction/control logic and the slice instance in the parent datapath.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_nibble_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_nibble_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer and the external 4-bit slice.
package alu_seq_pkg;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
  } Alu4bitArgs;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SHR  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  localparam logic [1:0] ALU_CMD_SUM = 2'd0;
  localparam logic [1:0] ALU_CMD_SHR = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_nibble_seq.sv
// Drives an external 4-bit ALU slice one nibble per cycle, LSB first, and assembles a WIDTH-bit result.
// Optional macro ALU_NIBBLE_SEQ_OVERFLOW_EN adds the signed-overflow output rsp_ovf.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  output logic             rsp_ovf,
`endif
  output logic [7:0]       alu_args,
  output logic             alu_carry_in,
  output logic             alu_carry_disable,
  output logic [1:0]       alu_cmd,
  input  logic [3:0]       alu_res,
  input  logic             alu_carry_out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("alu_nibble_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e             state_r, state_s;
  op_e                op_r;
  logic [WIDTH-1:0]   a_r, b_r, result_r, result_next_s, b_shr_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r, last_s, accept_s, req_ready_r, req_ready_s;
  logic [3:0]         cap_nib_s, a_nib_s, b_nib_s;
  Alu4bitArgs         alu_args_s;
  logic               alu_carry_in_s, alu_carry_disable_s;
  logic [1:0]         alu_cmd_s;
  logic               rsp_valid_r, rsp_carry_r, rsp_zero_r, rsp_err_r;
  logic [WIDTH-1:0]   rsp_data_r;

  assign accept_s = req_valid && req_ready_r && (state_r == IDLE);
  assign last_s   = (idx_r == IDX_W'(NIBBLES - 1));
  assign a_nib_s  = a_r[4*idx_r +: 4];
  assign b_nib_s  = b_r[4*idx_r +: 4];
  assign b_shr_s  = {1'b0, b_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (req_op == OP_RSVD) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Slice drive and ready decode; the slice is combinational so it is driven straight from the registers.
  always_comb begin
    alu_args_s          = '0;
    alu_carry_in_s      = 1'b0;
    alu_carry_disable_s = 1'b0;
    alu_cmd_s           = ALU_CMD_SUM;
    req_ready_s         = (state_s == IDLE);
    if (state_r == RUN) begin
      case (op_r)
        OP_ADD: begin
          alu_args_s     = '{d1: a_nib_s, d2: b_nib_s};
          alu_carry_in_s = (idx_r == '0) ? 1'b0 : carry_r;
        end
        OP_SUB: begin
          alu_args_s     = '{d1: a_nib_s, d2: ~b_nib_s};
          alu_carry_in_s = (idx_r == '0) ? 1'b1 : carry_r;
        end
        OP_SHR: begin
          alu_args_s          = '{d1: 4'h0, d2: b_nib_s};
          alu_carry_disable_s = 1'b1;
          alu_cmd_s           = ALU_CMD_SHR;
        end
        default: alu_args_s = '0;
      endcase
    end else begin
      alu_args_s = '0;
    end
  end

  // Captured nibble; for SHR bit 3 comes from the next nibble of B since the slice cannot see it.
  always_comb begin
    cap_nib_s = alu_res;
    if (op_r == OP_SHR) begin
      cap_nib_s[3] = b_shr_s[4*idx_r+3];
    end else begin
      cap_nib_s[3] = alu_res[3];
    end
    result_next_s = result_r;
    result_next_s[4*idx_r +: 4] = cap_nib_s;
  end

`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  logic b_top_s, cin_top_s, ovf_s, rsp_ovf_r;

  // Signed overflow: carry into the top bit XOR carry out of it.
  always_comb begin
    b_top_s   = (op_r == OP_SUB) ? ~b_r[WIDTH-1] : b_r[WIDTH-1];
    cin_top_s = a_r[WIDTH-1] ^ b_top_s ^ alu_res[3];
    if ((op_r == OP_ADD) || (op_r == OP_SUB)) begin
      ovf_s = cin_top_s ^ alu_carry_out;
    end else begin
      ovf_s = 1'b0;
    end
  end

  // Overflow flag register, follows the response life cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      rsp_ovf_r <= ovf_s;
    end else if ((state_r == DONE) && rsp_ready) begin
      rsp_ovf_r <= 1'b0;
    end
  end

  assign rsp_ovf = rsp_ovf_r;
`endif

  // Operand latch, nibble walk and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= OP_ADD;
      a_r         <= '0;
      b_r         <= '0;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      result_r    <= '0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_carry_r <= 1'b0;
      rsp_zero_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      req_ready_r <= req_ready_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r     <= op_e'(req_op);
            a_r      <= req_a;
            b_r      <= req_b;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            result_r <= '0;
            if (req_op == OP_RSVD) begin
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= '0;
              rsp_carry_r <= 1'b0;
              rsp_zero_r  <= 1'b1;
              rsp_err_r   <= 1'b1;
            end
          end
        end
        RUN: begin
          result_r <= result_next_s;
          carry_r  <= alu_carry_out;
          idx_r    <= idx_r + IDX_W'(1);
          if (last_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= result_next_s;
            rsp_carry_r <= (op_r == OP_SHR) ? b_r[0] : alu_carry_out;
            rsp_zero_r  <= (result_next_s == '0);
            rsp_err_r   <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_carry_r <= 1'b0;
            rsp_zero_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
          end
        end
        default: idx_r <= '0;
      endcase
    end
  end

  assign req_ready         = req_ready_r;
  assign rsp_valid         = rsp_valid_r;
  assign rsp_data          = rsp_data_r;
  assign rsp_carry         = rsp_carry_r;
  assign rsp_zero          = rsp_zero_r;
  assign rsp_err           = rsp_err_r;
  assign alu_args          = alu_args_s;
  assign alu_carry_in      = alu_carry_in_s;
  assign alu_carry_disable = alu_carry_disable_s;
  assign alu_cmd           = alu_cmd_s;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed table-driven bench for alu_nibble_seq with a behavioural model of the 4-bit slice.
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_zero, rsp_err;
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  logic        rsp_ovf;
`endif
  logic [7:0]  alu_args;
  logic        alu_carry_in, alu_carry_disable;
  logic [1:0]  alu_cmd;
  logic [3:0]  alu_res;
  logic        alu_carry_out;

  int total = 0;
  int bad   = 0;

  alu_nibble_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
    .rsp_ovf(rsp_ovf),
`endif
    .alu_args(alu_args), .alu_carry_in(alu_carry_in), .alu_carry_disable(alu_carry_disable),
    .alu_cmd(alu_cmd), .alu_res(alu_res), .alu_carry_out(alu_carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slice model: SHR rotates, so bit 3 of its result is deliberately not a usable shift bit.
  logic [4:0] sum5;
  always_comb begin
    sum5 = 5'd0;
    if (alu_cmd == ALU_CMD_SHR) begin
      alu_res       = {alu_args[0], alu_args[3:1]};
      alu_carry_out = alu_args[0];
    end else begin
      sum5          = {1'b0, alu_args[7:4]} + {1'b0, alu_args[3:0]} +
                      {4'd0, (alu_carry_disable ? 1'b0 : alu_carry_in)};
      alu_res       = sum5[3:0];
      alu_carry_out = sum5[4];
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        carry;
    logic        zero;
    logic        err;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    int cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'd3;
    req_a     = 16'hDEAD;
    req_b     = 16'hBEEF;
  endtask

  task automatic do_op(input vec_t v, input int n);
    int cyc;
    start_op(v);
    if (v.op != 2'd3) begin
      chk($sformatf("v%0d_first_carry_in", n), {31'd0, alu_carry_in}, {31'd0, (v.op == 2'd1)});
      chk($sformatf("v%0d_carry_disable", n), {31'd0, alu_carry_disable}, {31'd0, (v.op == 2'd2)});
    end
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d_latency", n), cyc, v.err ? 32'd1 : 32'd5);
    chk($sformatf("v%0d_data", n), {16'd0, rsp_data}, {16'd0, v.data});
    chk($sformatf("v%0d_carry", n), {31'd0, rsp_carry}, {31'd0, v.carry});
    chk($sformatf("v%0d_zero", n), {31'd0, rsp_zero}, {31'd0, v.zero});
    chk($sformatf("v%0d_err", n), {31'd0, rsp_err}, {31'd0, v.err});
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
    chk($sformatf("v%0d_ovf", n), {31'd0, rsp_ovf}, {31'd0, v.ovf});
`endif
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_valid_drop", n), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_back", n), {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 16'd0; req_b = 16'd0; rsp_ready = 1'b0;

    //            op     a         b         data      c     z     e     ovf
    vecs[0]  = '{2'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{2'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{2'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'd2, 16'h0000, 16'h8421, 16'h4210, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'd2, 16'h5555, 16'h0010, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'd2, 16'h0000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'd3, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};

    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp", {14'd0, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    chk("reset_alu", {20'd0, alu_args, alu_carry_in, alu_carry_disable, alu_cmd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i], i);
    end

    // Backpressure: response held three cycles while a new request is offered.
    v = '{2'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
    start_op(v);
    for (int c = 0; c < 10 && !rsp_valid; c++) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_op = 2'd1; req_a = 16'h00AA; req_b = 16'h0055;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {16'd0, rsp_data}, 32'h0007);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_alu_idle", {20'd0, alu_args, alu_carry_in, alu_carry_disable, alu_cmd}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (7) @(negedge clk);
    chk("bp_no_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);

    // Reset in the second RUN cycle, after nibble 0 produced a carry.
    v = '{2'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    start_op(v);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_rsp", {14'd0, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    chk("midrun_rst_alu", {20'd0, alu_args, alu_carry_in, alu_carry_disable, alu_cmd}, 32'd0);
    chk("midrun_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{2'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    do_op(v, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
